// File: rtl/arith_trunci_buf_if.sv
// Operand/result handshake bundle for the truncating elastic buffer.
// The master side drives operands and result_ready; the slave side is the buffer.
interface arith_trunci_buf_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16
);
  logic                 a_valid;
  logic                 a_ready;
  logic [IN_WIDTH-1:0]  a_data;
  logic                 result_valid;
  logic                 result_ready;
  logic [OUT_WIDTH-1:0] result_data;
  logic                 result_lossy;

  modport master (
    output a_valid, output a_data, input a_ready,
    input result_valid, input result_data, input result_lossy, output result_ready
  );

  modport slave (
    input a_valid, input a_data, output a_ready,
    output result_valid, output result_data, output result_lossy, input result_ready
  );
endinterface

// File: rtl/arith_trunci_buf.sv
// Integer narrowing stage: keeps the low OUT_WIDTH bits of each operand in a
// registered 2-entry elastic buffer, flags lossy beats and counts them.
module arith_trunci_buf #(
  parameter int IN_WIDTH     = 32,
  parameter int OUT_WIDTH    = 16,
  parameter int SIGNED_CHECK = 0,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  arith_trunci_buf_if.slave    bus,
  input  logic                 lossy_clr,
  output logic [CNT_WIDTH-1:0] lossy_count
);
  generate
    if (OUT_WIDTH < 1 || OUT_WIDTH >= IN_WIDTH) begin : g_bad_width
      $error("arith_trunci_buf: OUT_WIDTH must satisfy 1 <= OUT_WIDTH < IN_WIDTH");
    end
  endgenerate

  localparam int DROP_WIDTH = IN_WIDTH - OUT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DROP_WIDTH-1:0] upper_bits;
  logic                  in_lossy;
  logic [OUT_WIDTH-1:0]  data_q [2];
  logic [1:0]            lossy_q;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  a_ready_q;
  logic                  result_valid;
  logic                  accept;
  logic                  emit;

  assign upper_bits = bus.a_data[IN_WIDTH-1:OUT_WIDTH];

  // A signed value survives narrowing only if the dropped bits replicate the new sign bit.
  generate
    if (SIGNED_CHECK != 0) begin : g_signed
      assign in_lossy = (upper_bits != {DROP_WIDTH{bus.a_data[OUT_WIDTH-1]}});
    end else begin : g_unsigned
      assign in_lossy = |upper_bits;
    end
  endgenerate

  assign result_valid = (occ != 2'd0);
  assign accept       = bus.a_valid && a_ready_q;
  assign emit         = result_valid && bus.result_ready;

  always_comb begin
    occ_next = occ;
    case ({accept, emit})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // a_ready looks only at the next occupancy, so result_ready never reaches it combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      a_ready_q <= 1'b0;
    end else begin
      occ       <= occ_next;
      a_ready_q <= (occ_next != 2'd2);
      if (accept) wr_ptr <= ~wr_ptr;
      if (emit)   rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[wr_ptr]  <= bus.a_data[OUT_WIDTH-1:0];
      lossy_q[wr_ptr] <= in_lossy;
    end
  end

  // A clear that lands on a lossy accept restarts at one so that event is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lossy_count <= '0;
    end else if (lossy_clr) begin
      lossy_count <= (accept && in_lossy) ? CNT_ONE : '0;
    end else if (accept && in_lossy && lossy_count != CNT_MAX) begin
      lossy_count <= lossy_count + CNT_ONE;
    end
  end

  assign bus.a_ready      = a_ready_q;
  assign bus.result_valid = result_valid;
  assign bus.result_data  = data_q[rd_ptr];
  assign bus.result_lossy = lossy_q[rd_ptr];
endmodule

// File: tb/tb_arith_trunci_buf.sv
// Self-checking bench for arith_trunci_buf: unsigned 8-bit-counter, signed and
// 2-bit-counter instances checked against a queue-based reference model.
module tb_arith_trunci_buf;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       lossy_clr_m, lossy_clr_s, lossy_clr_c;
  logic [7:0] lossy_count_m, lossy_count_s;
  logic [1:0] lossy_count_c;

  arith_trunci_buf_if #(.IN_WIDTH(32), .OUT_WIDTH(16)) m_if (), s_if (), c_if ();

  arith_trunci_buf #(.IN_WIDTH(32), .OUT_WIDTH(16), .SIGNED_CHECK(0), .CNT_WIDTH(8)) dut_m (
    .clk(clk), .rst(rst), .bus(m_if.slave), .lossy_clr(lossy_clr_m), .lossy_count(lossy_count_m));
  arith_trunci_buf #(.IN_WIDTH(32), .OUT_WIDTH(16), .SIGNED_CHECK(1), .CNT_WIDTH(8)) dut_s (
    .clk(clk), .rst(rst), .bus(s_if.slave), .lossy_clr(lossy_clr_s), .lossy_count(lossy_count_s));
  arith_trunci_buf #(.IN_WIDTH(32), .OUT_WIDTH(16), .SIGNED_CHECK(0), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if.slave), .lossy_clr(lossy_clr_c), .lossy_count(lossy_count_c));

  int total = 0;
  int bad   = 0;

  // Reference model of the unsigned instance: plain FIFO of {lossy, data} beats.
  logic [16:0] exp_q[$];
  logic [16:0] sent_q[$];
  logic [16:0] got_q[$];
  int          m_cnt   = 0;
  bit          m_ready = 1'b0;

  function automatic bit lossy_u(input logic [31:0] v);
    return v > 32'h0000_FFFF;
  endfunction

  function automatic bit lossy_s(input logic [31:0] v);
    int signed sv;
    sv = $signed(v);
    return (sv < -32768) || (sv > 32767);
  endfunction

  always @(negedge clk)
    if (rst === 1'b0 && m_if.result_valid === 1'b1 && m_if.result_ready === 1'b1)
      got_q.push_back({m_if.result_lossy, m_if.result_data});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_m(input bit va, input logic [31:0] d, input bit rr, input bit clr);
    bit acc, emt, lz;
    m_if.a_valid = va;
    m_if.a_data = d;
    m_if.result_ready = rr;
    lossy_clr_m = clr;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt   = 0;
      m_ready = 1'b0;
    end else begin
      acc = va && m_ready;
      emt = rr && (exp_q.size() != 0);
      lz  = lossy_u(d);
      if (emt) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({lz, d[15:0]});
        sent_q.push_back({lz, d[15:0]});
      end
      if (clr) m_cnt = (acc && lz) ? 1 : 0;
      else if (acc && lz && m_cnt < 255) m_cnt++;
      m_ready = (exp_q.size() < 2);
    end
    #1;
  endtask

  task automatic test_reset();
    int n0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_m(1'b0, '0, 1'b0, 1'b0);
      total++; if (m_if.result_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", m_if.result_valid); end
      total++; if (m_if.a_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", m_if.a_ready); end
      total++; if (lossy_count_m !== 8'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", lossy_count_m); end
    end
    rst = 1'b0;
    cycle_m(1'b0, '0, 1'b0, 1'b0);
    total++; if (m_if.a_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b exp=1", m_if.a_ready); end
    cycle_m(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    cycle_m(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    total++; if (m_if.result_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_valid got=%b exp=1", m_if.result_valid); end
    total++; if (m_if.a_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%b exp=0", m_if.a_ready); end
    n0 = got_q.size();
    rst = 1'b1;
    cycle_m(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    total++; if (m_if.result_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_valid got=%b exp=0", m_if.result_valid); end
    cycle_m(1'b0, '0, 1'b1, 1'b0);
    cycle_m(1'b0, '0, 1'b1, 1'b0);
    total++; if (m_if.result_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_drop got=%b exp=0", m_if.result_valid); end
    total++; if (got_q.size() !== n0) begin bad++; $display("[TB] FAIL midreset_emits got=%0d exp=%0d", got_q.size(), n0); end
    total++; if (lossy_count_m !== 8'd0) begin bad++; $display("[TB] FAIL midreset_count got=%0d exp=0", lossy_count_m); end
  endtask

  task automatic test_single_beat();
    cycle_m(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    total++; if (m_if.result_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b exp=1", m_if.result_valid); end
    total++; if (m_if.result_data !== 16'h1234) begin bad++; $display("[TB] FAIL single_data got=%h exp=1234", m_if.result_data); end
    total++; if (m_if.result_lossy !== 1'b0) begin bad++; $display("[TB] FAIL single_lossy got=%b exp=0", m_if.result_lossy); end
    cycle_m(1'b0, '0, 1'b1, 1'b0);
    total++; if (m_if.result_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%b exp=0", m_if.result_valid); end
    total++; if (lossy_count_m !== 8'd0) begin bad++; $display("[TB] FAIL single_count got=%0d exp=0", lossy_count_m); end
  endtask

  task automatic test_backpressure();
    int n0;
    logic [16:0] want [3];
    want = '{{1'b1, 16'h0001}, {1'b0, 16'h0002}, {1'b0, 16'h0003}};
    n0 = got_q.size();
    cycle_m(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle_m(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    total++; if (m_if.a_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_full got=%b exp=0", m_if.a_ready); end
    cycle_m(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    total++; if (m_if.a_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready_held got=%b exp=0", m_if.a_ready); end
    total++; if (m_if.result_data !== 16'h0001) begin bad++; $display("[TB] FAIL bp_head_stable got=%h exp=0001", m_if.result_data); end
    cycle_m(1'b1, 32'h0000_0003, 1'b1, 1'b0);
    cycle_m(1'b1, 32'h0000_0003, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle_m(1'b0, '0, 1'b1, 1'b0);
    total++; if (got_q.size() - n0 !== 3) begin bad++; $display("[TB] FAIL bp_emit_count got=%0d exp=3", got_q.size() - n0); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (got_q.size() <= n0 + k || got_q[n0+k] !== want[k]) begin
        bad++; $display("[TB] FAIL bp_beat%0d got=%h exp=%h", k, (got_q.size() > n0 + k) ? got_q[n0+k] : 17'h0, want[k]);
      end
    end
    total++; if (lossy_count_m !== 8'd1) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=1", lossy_count_m); end
  endtask

  task automatic test_streaming();
    int n0;
    logic [31:0] base, v;
    logic [16:0] want;
    n0 = got_q.size();
    base = $urandom;
    for (int i = 0; i < 100; i++) begin
      cycle_m(1'b1, base + 32'(i), 1'b1, 1'b0);
      total++; if (m_if.a_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready cyc=%0d got=%b exp=1", i, m_if.a_ready); end
      total++; if (m_if.result_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid cyc=%0d got=%b exp=1", i, m_if.result_valid); end
    end
    total++; if (got_q.size() - n0 !== 99) begin bad++; $display("[TB] FAIL stream_emits got=%0d exp=99", got_q.size() - n0); end
    for (int k = 0; k < 99 && n0 + k < got_q.size(); k++) begin
      v = base + 32'(k);
      want = {lossy_u(v), v[15:0]};
      total++; if (got_q[n0+k] !== want) begin bad++; $display("[TB] FAIL stream_beat%0d got=%h exp=%h", k, got_q[n0+k], want); end
    end
    for (int i = 0; i < 3; i++) cycle_m(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random_throttle();
    int n0, s0, n;
    n0 = got_q.size();
    s0 = sent_q.size();
    for (int i = 0; i < 300; i++) begin
      cycle_m(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 15) == 0);
      total++; if (m_if.result_valid !== (exp_q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b exp=%b", i, m_if.result_valid, exp_q.size() != 0); end
      total++; if (m_if.a_ready !== m_ready) begin bad++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b exp=%b", i, m_if.a_ready, m_ready); end
      total++; if (lossy_count_m !== 8'(m_cnt)) begin bad++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, lossy_count_m, m_cnt); end
      if (exp_q.size() != 0) begin
        total++; if ({m_if.result_lossy, m_if.result_data} !== exp_q[0]) begin bad++; $display("[TB] FAIL rnd_head cyc=%0d got=%h exp=%h", i, {m_if.result_lossy, m_if.result_data}, exp_q[0]); end
      end
    end
    for (int i = 0; i < 4; i++) cycle_m(1'b0, '0, 1'b1, 1'b0);
    n = sent_q.size() - s0;
    total++; if (got_q.size() - n0 !== n) begin bad++; $display("[TB] FAIL rnd_emit_count got=%0d exp=%0d", got_q.size() - n0, n); end
    for (int k = 0; k < n && n0 + k < got_q.size(); k++) begin
      total++; if (got_q[n0+k] !== sent_q[s0+k]) begin bad++; $display("[TB] FAIL rnd_order%0d got=%h exp=%h", k, got_q[n0+k], sent_q[s0+k]); end
    end
  endtask

  task automatic test_signed();
    logic [31:0] vals [4];
    bit          lz   [4];
    logic [31:0] v;
    vals = '{32'hFFFF_8000, 32'hFFFF_7FFF, 32'h0000_8000, 32'h0000_7FFF};
    lz   = '{1'b0, 1'b1, 1'b1, 1'b0};
    s_if.result_ready = 1'b1;
    for (int i = 0; i < 28; i++) begin
      if (i < 4) v = vals[i];
      else begin
        v = $urandom;
        if (v[20]) v = {{16{v[15]}}, v[15:0]};
      end
      s_if.a_valid = 1'b1;
      s_if.a_data = v;
      tick();
      total++; if (s_if.result_valid !== 1'b1 || s_if.result_data !== v[15:0]) begin bad++; $display("[TB] FAIL signed_data%0d got=%b/%h exp=1/%h", i, s_if.result_valid, s_if.result_data, v[15:0]); end
      total++; if (s_if.result_lossy !== lossy_s(v)) begin bad++; $display("[TB] FAIL signed_lossy%0d val=%h got=%b exp=%b", i, v, s_if.result_lossy, lossy_s(v)); end
      if (i < 4) begin
        total++; if (s_if.result_lossy !== lz[i]) begin bad++; $display("[TB] FAIL signed_const%0d got=%b exp=%b", i, s_if.result_lossy, lz[i]); end
      end
    end
    s_if.a_valid = 1'b0;
    tick();
    cycle_m(1'b1, 32'hFFFF_8000, 1'b1, 1'b0);
    total++; if (m_if.result_lossy !== 1'b1) begin bad++; $display("[TB] FAIL unsigned_ffff8000 got=%b exp=1", m_if.result_lossy); end
    cycle_m(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_counter();
    int exp_c;
    exp_c = 0;
    c_if.result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      c_if.a_valid = 1'b1;
      c_if.a_data = 32'h0001_0000 + 32'(i);
      tick();
      exp_c = (exp_c < 3) ? exp_c + 1 : 3;
      total++; if (lossy_count_c !== 2'(exp_c)) begin bad++; $display("[TB] FAIL cnt_step%0d got=%0d exp=%0d", i, lossy_count_c, exp_c); end
    end
    total++; if (lossy_count_c !== 2'd3) begin bad++; $display("[TB] FAIL cnt_saturate got=%0d exp=3", lossy_count_c); end
    c_if.a_valid = 1'b0;
    lossy_clr_c = 1'b1;
    tick();
    total++; if (lossy_count_c !== 2'd0) begin bad++; $display("[TB] FAIL cnt_clear got=%0d exp=0", lossy_count_c); end
    c_if.a_valid = 1'b1;
    c_if.a_data = 32'h8000_0000;
    tick();
    total++; if (lossy_count_c !== 2'd1) begin bad++; $display("[TB] FAIL cnt_clear_accept got=%0d exp=1", lossy_count_c); end
    lossy_clr_c = 1'b0;
    c_if.a_data = 32'h0000_0005;
    tick();
    total++; if (lossy_count_c !== 2'd1) begin bad++; $display("[TB] FAIL cnt_clean_beat got=%0d exp=1", lossy_count_c); end
    c_if.a_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    lossy_clr_m = 1'b0; lossy_clr_s = 1'b0; lossy_clr_c = 1'b0;
    m_if.a_valid = 1'b0; m_if.a_data = '0; m_if.result_ready = 1'b0;
    s_if.a_valid = 1'b0; s_if.a_data = '0; s_if.result_ready = 1'b0;
    c_if.a_valid = 1'b0; c_if.a_data = '0; c_if.result_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_streaming();
    test_random_throttle();
    test_signed();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
